// File: rtl/meas_frame_writer.sv
// Serial-to-parallel measurement frame assembler: gathers 16/32/48 words, holds the frame until ack.
// Optional MEAS_FRAME_SUM_EN adds a running modulo-2^DATA_W sum output (frame_sum_o).
module meas_frame_writer #(
  parameter int DATA_W   = 16,
  parameter int MAX_MEAS = 48
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [7:0]                 meas_num_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [MAX_MEAS*DATA_W-1:0] frame_data_o,
  output logic                       frame_valid_o,
  input  logic                       frame_ack_i,
  output logic [7:0]                 frame_len_o,
  output logic                       cfg_err_o,
  output logic [15:0]                frame_count_o
`ifdef MEAS_FRAME_SUM_EN
  ,
  output logic [DATA_W-1:0]          frame_sum_o
`endif
);

  localparam int IDX_W = $clog2(MAX_MEAS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] mem_q [MAX_MEAS];
  logic [DATA_W-1:0] mem_d [MAX_MEAS];
  logic [7:0]        len_q, len_d;
  logic              cfg_err_q, cfg_err_d;
  logic [15:0]       count_q, count_d;
`ifdef MEAS_FRAME_SUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  logic accept;
  logic legal_len;
  logic last_word;
  logic clear;

  assign accept    = in_valid_i && in_ready_o;
  assign legal_len = (meas_num_i == 8'd16) || (meas_num_i == 8'd32) || (meas_num_i == 8'd48);
  assign last_word = (state_q == S_FILL) && (8'(wr_idx_q) == len_q - 8'd1);
  assign clear     = (state_q == S_HOLD) && frame_ack_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FILL;
      S_FILL:  if (accept && last_word) state_d = S_HOLD;
      S_HOLD:  if (frame_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o    = (state_q != S_HOLD);
    frame_valid_o = (state_q == S_HOLD);
  end

  // wr_idx is 0 whenever IDLE, so IDLE and FILL share the same write path
  always_comb begin
    mem_d     = mem_q;
    wr_idx_d  = wr_idx_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;
    count_d   = count_q;
    for (int k = 0; k < MAX_MEAS; k++) begin
      if (accept && (wr_idx_q == IDX_W'(k))) mem_d[k] = in_data_i;
      if (clear) mem_d[k] = '0;
    end
    if (accept && (state_q == S_IDLE)) begin
      len_d     = legal_len ? meas_num_i : 8'd16;
      cfg_err_d = !legal_len;
      wr_idx_d  = IDX_W'(1);
    end else if (accept && (state_q == S_FILL)) begin
      if (last_word) count_d = count_q + 16'd1;
      else           wr_idx_d = wr_idx_q + IDX_W'(1);
    end
    if (clear) wr_idx_d = '0;
  end

`ifdef MEAS_FRAME_SUM_EN
  always_comb begin
    sum_d = sum_q;
    if (accept) sum_d = sum_q + in_data_i;
    if (clear)  sum_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  assign frame_sum_o = sum_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < MAX_MEAS; k++) mem_q[k] <= '0;
      wr_idx_q  <= '0;
      len_q     <= '0;
      cfg_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_idx_q  <= wr_idx_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    frame_data_o = '0;
    for (int k = 0; k < MAX_MEAS; k++) frame_data_o[k*DATA_W +: DATA_W] = mem_q[k];
  end

  assign frame_len_o   = len_q;
  assign cfg_err_o     = cfg_err_q;
  assign frame_count_o = count_q;

endmodule
